// File: rtl/generador_secuencia_sensores.sv
// a/b sensor waveform generator emulating a car crossing the two-sensor gate,
// with occupancy tracking and refusal of impossible entry/exit requests.
module generador_secuencia_sensores #(
  parameter int PHASE_CYCLES = 240000,
  parameter int PHASE_W      = 18,
  parameter int CAPACITY     = 7,
  parameter int OCC_W        = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_in,
  input  logic             req_out,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic             rejected,
  output logic [OCC_W-1:0] occupancy
);

  typedef enum logic [2:0] {
    IDLE,
    P1,
    P2,
    P3,
    GAP
  } state_t;

  localparam logic [PHASE_W-1:0] LAST = PHASE_W'(PHASE_CYCLES - 1);
  localparam logic [OCC_W-1:0]   CAP  = OCC_W'(CAPACITY);

  state_t             state_q, state_d;
  logic [PHASE_W-1:0] cnt_q;
  logic               dir_q;
  logic [1:0]         ab_q;
  logic               busy_q, done_q, rej_q;
  logic [OCC_W-1:0]   occ_q;

  logic acc_in, acc_out, refuse;

  // dir: 0 = entry (a leads), 1 = exit (b leads)
  function automatic logic [1:0] ab_of(state_t s, logic ex);
    logic [1:0] r;
    r = 2'b00;
    case (s)
      P1:      r = ex ? 2'b01 : 2'b10;
      P2:      r = 2'b11;
      P3:      r = ex ? 2'b10 : 2'b01;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  assign acc_in  = req_in & ~req_out & (occ_q < CAP);
  assign acc_out = req_out & ~req_in & (occ_q != '0);
  assign refuse  = (req_in | req_out) & ~acc_in & ~acc_out;

  always_comb begin
    state_d = IDLE;
    case (state_q)
      P1:      state_d = P2;
      P2:      state_d = P3;
      P3:      state_d = GAP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      ab_q    <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rej_q   <= 1'b0;
      occ_q   <= '0;
    end else begin
      done_q <= 1'b0;
      rej_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (acc_in) begin
            state_q <= P1;
            dir_q   <= 1'b0;
            busy_q  <= 1'b1;
            ab_q    <= 2'b10;
          end else if (acc_out) begin
            state_q <= P1;
            dir_q   <= 1'b1;
            busy_q  <= 1'b1;
            ab_q    <= 2'b01;
          end else if (refuse) begin
            rej_q <= 1'b1;
          end
        end
        default: begin
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            state_q <= state_d;
            ab_q    <= ab_of(state_d, dir_q);
            if (state_q == GAP) begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              occ_q  <= dir_q ? occ_q - OCC_W'(1) : occ_q + OCC_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + PHASE_W'(1);
          end
        end
      endcase
    end
  end

  assign a         = ab_q[1];
  assign b         = ab_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign rejected  = rej_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_generador_secuencia_sensores.sv
// Scoreboard bench: stimulus queues expected done/rejected events,
// a negedge monitor pops and checks occupancy and the captured a/b trace.
module tb_generador_secuencia_sensores;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_in = 1'b0;
  logic       req_out = 1'b0;
  logic       a, b, busy, done, rejected;
  logic [1:0] occupancy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          rej;
    logic [1:0]  occ;
    logic [31:0] tr;
  } exp_t;

  exp_t sb[$];

  localparam logic [31:0] TR_IN  = {{4{2'b10}}, {4{2'b11}}, {4{2'b01}}, {4{2'b00}}};
  localparam logic [31:0] TR_OUT = {{4{2'b01}}, {4{2'b11}}, {4{2'b10}}, {4{2'b00}}};

  generador_secuencia_sensores #(
    .PHASE_CYCLES(4),
    .PHASE_W(3),
    .CAPACITY(3),
    .OCC_W(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_in(req_in),
    .req_out(req_out),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .rejected(rejected),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor
  logic [31:0] trace = '0;
  int          n = 0;
  always @(negedge clk) begin
    if (rst) begin
      trace = '0;
      n = 0;
    end else begin
      check("ab_overlap", 32'(a & b & ~busy), 32'd0);
      if (busy) begin
        trace = {trace[29:0], a, b};
        n++;
      end
      if (done || rejected) begin
        if (sb.size() == 0) begin
          check("unexpected_event", {30'd0, done, rejected}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("event_kind", {30'd0, done, rejected}, e.rej ? 32'd1 : 32'd2);
          check("occupancy", 32'(occupancy), 32'(e.occ));
          if (!e.rej) begin
            check("busy_len", 32'(n), 32'd16);
            check("ab_trace", trace, e.tr);
          end else begin
            check("rej_no_ab", {30'd0, a, b}, 32'd0);
          end
        end
        trace = '0;
        n = 0;
      end
    end
  end

  task automatic pulse(bit i, bit o);
    @(posedge clk);
    #1;
    req_in  = i;
    req_out = o;
    @(posedge clk);
    #1;
    req_in  = 1'b0;
    req_out = 1'b0;
  endtask

  task automatic push(bit rej, logic [1:0] occ, logic [31:0] tr);
    exp_t e;
    e.rej = rej;
    e.occ = occ;
    e.tr  = tr;
    sb.push_back(e);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 60) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {26'd0, a, b, busy, done, rejected, 1'b0},
          32'd0);
    check("rst_occ", 32'(occupancy), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // exit at empty is refused
    push(1'b1, 2'd0, '0);
    pulse(1'b0, 1'b1);
    drain();
    check("idle_after_rej", {30'd0, busy, a | b}, 32'd0);

    // fill the lot
    push(1'b0, 2'd1, TR_IN);
    pulse(1'b1, 1'b0);
    drain();
    push(1'b0, 2'd2, TR_IN);
    pulse(1'b1, 1'b0);
    drain();
    push(1'b0, 2'd3, TR_IN);
    pulse(1'b1, 1'b0);
    drain();

    // full: entry refused
    push(1'b1, 2'd3, '0);
    pulse(1'b1, 1'b0);
    drain();
    check("full_occ", 32'(occupancy), 32'd3);

    // empty the lot
    push(1'b0, 2'd2, TR_OUT);
    pulse(1'b0, 1'b1);
    drain();
    push(1'b0, 2'd1, TR_OUT);
    pulse(1'b0, 1'b1);
    drain();
    push(1'b0, 2'd0, TR_OUT);
    pulse(1'b0, 1'b1);
    drain();

    // both requests together
    push(1'b1, 2'd0, '0);
    pulse(1'b1, 1'b1);
    drain();

    // requests while busy are ignored
    push(1'b0, 2'd1, TR_IN);
    pulse(1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    req_in = 1'b1;
    req_out = 1'b1;
    @(posedge clk);
    #1;
    req_out = 1'b0;
    @(posedge clk);
    #1;
    req_in = 1'b0;
    req_out = 1'b1;
    @(posedge clk);
    #1;
    req_out = 1'b0;
    drain();
    check("busy_ign_occ", 32'(occupancy), 32'd1);

    // held request re-accepted right after done
    push(1'b0, 2'd2, TR_IN);
    push(1'b0, 2'd3, TR_IN);
    @(posedge clk);
    #1;
    req_in = 1'b1;
    begin
      int k;
      k = 0;
      while (!done && k < 40) begin
        @(negedge clk);
        k++;
      end
    end
    @(posedge clk);
    #1;
    check("reaccept_busy", 32'(busy), 32'd1);
    req_in = 1'b0;
    drain();

    // reset mid-P2 of an exit
    pulse(1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("p2_ab", {30'd0, a, b}, 32'd3);
    #1;
    rst = 1'b1;
    #1;
    check("abort_out", {29'd0, a, b, busy}, 32'd0);
    check("abort_occ", 32'(occupancy), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // works after abort
    push(1'b0, 2'd1, TR_IN);
    pulse(1'b1, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

endmodule
